instr_encoder: RTL and testbench

- Writer-side counterpart to the opcode decoder and the other end of the instruction-word interface.
- Accepts decoded instruction fields (format, registers, funct, immediate) over a valid/ready handshake and packs them into RV32 instruction words using the opcode set the processor decodes.
- Streams the words into instruction memory at consecutive word addresses and stops after a HALT word (opcode 1111111).
- Used by the self-test loader and testbenches to build programs in hardware.

---
 rtl/instr_encoder.sv | 132 +++++++++++++
 tb/tb_instr_encoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into RV32 words and streams them to instruction memory.
// Optional immediate range checking is enabled with the INSTR_ENCODER_IMM_CHECK_EN macro.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {ACCEPT, DONE, FULL} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_ptr;
  logic [31:0]       word;
  logic              xfer, is_halt, is_shift, rearm;

  assign xfer     = in_valid && in_ready;
  assign is_halt  = (in_type == 3'd7);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign rearm    = start && (state != ACCEPT);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // HALT takes priority over the last-address check, so full stays low.
          if (is_halt)        state_next = DONE;
          else if (&addr_ptr) state_next = FULL;
        end
      end
      DONE, FULL: if (start) state_next = ACCEPT;
      default:    state_next = ACCEPT;
    endcase
  end

  always_comb begin
    word = '0;
    case (in_type)
      3'd0: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd1: begin
        if (is_shift) word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else          word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      3'd2: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      3'd3: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      3'd4: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
      3'd5: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      3'd6: word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      default: word = 32'h0000007F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCEPT;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      addr_ptr <= '0;
      count    <= '0;
      done     <= 1'b0;
      full     <= 1'b0;
    end else begin
      state <= state_next;
      wr_en <= xfer;
      if (xfer) begin
        wr_addr  <= addr_ptr;
        wr_data  <= word;
        addr_ptr <= addr_ptr + ADDR_W'(1);
        count    <= count + (ADDR_W+1)'(1);
        if (is_halt)        done <= 1'b1;
        else if (&addr_ptr) full <= 1'b1;
      end else if (rearm) begin
        wr_addr  <= '0;
        addr_ptr <= '0;
        count    <= '0;
        done     <= 1'b0;
        full     <= 1'b0;
      end
    end
  end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  logic imm_bad;

  always_comb begin
    imm_bad = 1'b0;
    case (in_type)
      3'd1: begin
        if (is_shift) imm_bad = (in_imm[31:5] != '0);
        else          imm_bad = (in_imm[31:11] != {21{in_imm[11]}});
      end
      3'd2, 3'd3, 3'd6: imm_bad = (in_imm[31:11] != {21{in_imm[11]}});
      3'd4: imm_bad = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
      3'd5: imm_bad = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
      default: imm_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                  err <= 1'b0;
    else if (xfer && imm_bad) err <= 1'b1;
    else if (rearm)           err <= 1'b0;
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:21];
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-width instance and a 4-word instance share stimulus.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_type = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;

  logic        in_ready, wr_en, done, full, err;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  count;

  logic        s_in_ready, s_wr_en, s_done, s_full, s_err;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [2:0]  s_count;

  int checks = 0;
  int passes = 0;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  instr_encoder #(.ADDR_W(8)) dut_big (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
    .done(done), .full(full), .err(err)
  );

  instr_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .count(s_count),
    .done(s_done), .full(s_full), .err(s_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Present one bundle for one clock; outputs for that transfer are visible on return.
  task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wr_en, wr_addr, wr_data, count, done, full, err, in_ready} !==
        {1'b0, 8'd0, 32'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state got en=%b addr=%0d data=%h cnt=%0d done=%b full=%b err=%b rdy=%b exp 0/0/0/0/0/0/0/1",
               wr_en, wr_addr, wr_data, count, done, full, err, in_ready);
    else passes++;
  endtask

  task automatic test_r_type();
    do_reset();
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checks++;
    if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 8'd0, 32'h002081B3, 9'd1})
      $display("FAIL r_add got en=%b addr=%0d data=%h cnt=%0d exp 1/0/002081b3/1",
               wr_en, wr_addr, wr_data, count);
    else passes++;
    step();
    checks++;
    if (wr_en !== 1'b0) $display("FAIL idle_no_write got wr_en=%b exp 0", wr_en);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_type = 3'd1; in_rd = 5'd5; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'hFFFF_FFFF; in_valid = 1'b1;
    step();
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'd0, 32'hFFF00293})
      $display("FAIL b2b_i got en=%b addr=%0d data=%h exp 1/0/fff00293", wr_en, wr_addr, wr_data);
    else passes++;
    in_type = 3'd2; in_rd = 5'd0; in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_funct3 = 3'b010; in_imm = 32'd8;
    step();
    in_valid = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data, count} !== {1'b1, 8'd1, 32'h0020A423, 9'd2})
      $display("FAIL b2b_s got en=%b addr=%0d data=%h cnt=%0d exp 1/1/0020a423/2",
               wr_en, wr_addr, wr_data, count);
    else passes++;
  endtask

  task automatic test_branch_jal();
    do_reset();
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    checks++;
    if (wr_data !== 32'hFE208EE3) $display("FAIL beq got %h exp fe208ee3", wr_data);
    else passes++;
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    checks++;
    if ({wr_addr, wr_data} !== {8'd1, 32'h008000EF})
      $display("FAIL jal got addr=%0d data=%h exp 1/008000ef", wr_addr, wr_data);
    else passes++;
  endtask

  task automatic test_i_variants();
    do_reset();
    send(3'd6, 5'd1, 5'd2, 5'd0, 3'd3, 7'd0, 32'd4);
    checks++;
    if (wr_data !== 32'h004100E7) $display("FAIL jalr got %h exp 004100e7", wr_data);
    else passes++;
    send(3'd1, 5'd2, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'd3);
    checks++;
    if (wr_data !== 32'h4030D113) $display("FAIL srai got %h exp 4030d113", wr_data);
    else passes++;
    send(3'd3, 5'd4, 5'd2, 5'd31, 3'b010, 7'h7F, 32'hFFFF_FFF8);
    checks++;
    if (wr_data !== 32'hFF812203) $display("FAIL lw got %h exp ff812203", wr_data);
    else passes++;
  endtask

  task automatic test_halt();
    logic any_wr;
    do_reset();
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(3'd7, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF);
    checks++;
    if ({wr_en, wr_addr, wr_data, done, full, in_ready, count} !==
        {1'b1, 8'd2, 32'h0000007F, 1'b1, 1'b0, 1'b0, 9'd3})
      $display("FAIL halt got en=%b addr=%0d data=%h done=%b full=%b rdy=%b cnt=%0d exp 1/2/0000007f/1/0/0/3",
               wr_en, wr_addr, wr_data, done, full, in_ready, count);
    else passes++;
    any_wr = 1'b0;
    in_type = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (wr_en) any_wr = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if ({any_wr, count, done} !== {1'b0, 9'd3, 1'b1})
      $display("FAIL done_blocks got wrote=%b cnt=%0d done=%b exp 0/3/1", any_wr, count, done);
    else passes++;
    pulse_start();
    checks++;
    if ({in_ready, count, done} !== {1'b1, 9'd0, 1'b0})
      $display("FAIL rearm got rdy=%b cnt=%0d done=%b exp 1/0/0", in_ready, count, done);
    else passes++;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checks++;
    if ({wr_en, wr_addr, count} !== {1'b1, 8'd0, 9'd1})
      $display("FAIL rearm_write got en=%b addr=%0d cnt=%0d exp 1/0/1", wr_en, wr_addr, count);
    else passes++;
  endtask

  task automatic test_full();
    logic [1:0] exp_a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      exp_a = 2'(i);
      checks++;
      if ({s_wr_en, s_wr_addr} !== {1'b1, exp_a})
        $display("FAIL fill_addr%0d got en=%b addr=%0d exp 1/%0d", i, s_wr_en, s_wr_addr, exp_a);
      else passes++;
    end
    checks++;
    if ({s_full, s_done, s_in_ready, s_count} !== {1'b1, 1'b0, 1'b0, 3'd4})
      $display("FAIL full_flag got full=%b done=%b rdy=%b cnt=%0d exp 1/0/0/4",
               s_full, s_done, s_in_ready, s_count);
    else passes++;
    pulse_start();
    for (int i = 0; i < 3; i++) send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    checks++;
    if ({s_wr_addr, s_wr_data, s_done, s_full, s_in_ready} !== {2'd3, 32'h0000007F, 1'b1, 1'b0, 1'b0})
      $display("FAIL halt_last got addr=%0d data=%h done=%b full=%b rdy=%b exp 3/0000007f/1/0/0",
               s_wr_addr, s_wr_data, s_done, s_full, s_in_ready);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({wr_en, wr_addr, count} !== {1'b0, 8'd0, 9'd0})
      $display("FAIL reset_mid got en=%b addr=%0d cnt=%0d exp 0/0/0", wr_en, wr_addr, count);
    else passes++;
  endtask

  task automatic test_imm_err();
    do_reset();
    send(3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    checks++;
    if ({wr_data, err} !== {32'h00000013, EXP_ERR})
      $display("FAIL imm_range got data=%h err=%b exp 00000013/%b", wr_data, err, EXP_ERR);
    else passes++;
    step();
    pulse_start();
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checks++;
    if (err !== EXP_ERR) $display("FAIL err_sticky got %b exp %b", err, EXP_ERR);
    else passes++;
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    pulse_start();
    checks++;
    if (err !== 1'b0) $display("FAIL err_clear got %b exp 0", err);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_branch_jal();
    test_i_variants();
    test_halt();
    test_full();
    test_reset_mid();
    test_imm_err();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
